// File: rtl/mdu_defs.sv
// Shared MDU definitions: op encodings, FSM state encodings and default operand width.
// Divide support is enabled by defining MDU_DIV_EN.
package mdu_defs;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        FINISH = 2'b10
    } mdu_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational MDU iteration over {acc, opq}: shift-add multiply step or
// restoring-divide step. The divide path exists only when MDU_DIV_EN is defined.
module mdu_iter_step #(
    parameter int WIDTH = 32
) (
`ifdef MDU_DIV_EN
    input  logic             is_div,
`endif
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] opq,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] opq_next
);

    logic [WIDTH:0] sum_s;

    // Multiply: add the multiplicand when the current multiplier bit is set.
    assign sum_s = opq[0] ? ({1'b0, acc} + {1'b0, operand}) : {1'b0, acc};

`ifdef MDU_DIV_EN
    logic [WIDTH:0] shl_s;
    logic [WIDTH:0] diff_s;

    // Divide: shift next dividend bit into the remainder and trial-subtract the divisor.
    assign shl_s  = {acc, opq[WIDTH-1]};
    assign diff_s = shl_s - {1'b0, operand};

    // Select the multiply or divide step result.
    always_comb begin
        acc_next = sum_s[WIDTH:1];
        opq_next = {sum_s[0], opq[WIDTH-1:1]};
        if (is_div) begin
            if (!diff_s[WIDTH]) begin
                acc_next = diff_s[WIDTH-1:0];
                opq_next = {opq[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = shl_s[WIDTH-1:0];
                opq_next = {opq[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = sum_s[WIDTH:1];
            opq_next = {sum_s[0], opq[WIDTH-1:1]};
        end
    end
`else
    // Multiply step only: shift the carry and sum right into {acc, opq}.
    always_comb begin
        acc_next = sum_s[WIDTH:1];
        opq_next = {sum_s[0], opq[WIDTH-1:1]};
    end
`endif

endmodule

// File: rtl/mdu_hilo_unit.sv
// Iterative multiply/divide unit with HI/LO result registers and start/busy/done handshake.
// Define MDU_DIV_EN to include DIV/DIVU; otherwise divide ops complete immediately with no effect.
module mdu_hilo_unit
    import mdu_defs::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e         state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               is_div_r, is_div_s;
    logic               neg_res_r, neg_res_s;
    logic [WIDTH-1:0]   acc_r, acc_s, opq_r, opq_s, opd_r, opd_s;
    logic               busy_r, busy_s, done_r, done_s;
    logic [WIDTH-1:0]   hi_r, hi_s, lo_r, lo_s;
    logic [WIDTH-1:0]   acc_step_s, opq_step_s;
    logic [WIDTH-1:0]   rs_abs_s, rt_abs_s;
    logic               sgn_op_s;
    logic [2*WIDTH-1:0] prod_raw_s, prod_neg_s;

    assign sgn_op_s   = op_is_signed(op);
    assign rs_abs_s   = (sgn_op_s && rs_val[WIDTH-1]) ? (~rs_val + WIDTH'(1)) : rs_val;
    assign rt_abs_s   = (sgn_op_s && rt_val[WIDTH-1]) ? (~rt_val + WIDTH'(1)) : rt_val;
    assign prod_raw_s = {acc_r, opq_r};
    assign prod_neg_s = ~prod_raw_s + (2*WIDTH)'(1);

`ifdef MDU_DIV_EN
    logic             neg_rem_r, neg_rem_s, dz_r, dz_s, div_zero_r, div_zero_s;
    logic [WIDTH-1:0] rs_orig_r, rs_orig_s, quo_s, rem_s;

    assign quo_s = neg_res_r ? (~opq_r + WIDTH'(1)) : opq_r;
    assign rem_s = neg_rem_r ? (~acc_r + WIDTH'(1)) : acc_r;

    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div_r),
        .acc      (acc_r),
        .opq      (opq_r),
        .operand  (opd_r),
        .acc_next (acc_step_s),
        .opq_next (opq_step_s)
    );
`else
    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_r),
        .opq      (opq_r),
        .operand  (opd_r),
        .acc_next (acc_step_s),
        .opq_next (opq_step_s)
    );
`endif

    // Next-state, datapath and output logic for IDLE -> RUN -> FINISH sequencing.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        is_div_s  = is_div_r;
        neg_res_s = neg_res_r;
        acc_s     = acc_r;
        opq_s     = opq_r;
        opd_s     = opd_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        hi_s      = hi_r;
        lo_s      = lo_r;
`ifdef MDU_DIV_EN
        neg_rem_s  = neg_rem_r;
        dz_s       = dz_r;
        rs_orig_s  = rs_orig_r;
        div_zero_s = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (start) begin
                    is_div_s  = op[1];
                    neg_res_s = sgn_op_s && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                    cnt_s     = {CNT_W{1'b0}};
                    acc_s     = {WIDTH{1'b0}};
`ifdef MDU_DIV_EN
                    neg_rem_s = sgn_op_s && rs_val[WIDTH-1];
                    dz_s      = (rt_val == {WIDTH{1'b0}});
                    rs_orig_s = rs_val;
                    opq_s     = op[1] ? rs_abs_s : rt_abs_s;
                    opd_s     = op[1] ? rt_abs_s : rs_abs_s;
                    busy_s    = 1'b1;
                    state_s   = RUN;
`else
                    // Divide ops have no datapath here: finish next edge without busy.
                    if (op[1]) begin
                        busy_s  = 1'b0;
                        state_s = FINISH;
                    end else begin
                        opq_s   = rt_abs_s;
                        opd_s   = rs_abs_s;
                        busy_s  = 1'b1;
                        state_s = RUN;
                    end
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                acc_s = acc_step_s;
                opq_s = opq_step_s;
                cnt_s = cnt_r + CNT_W'(1);
                if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    state_s = FINISH;
                end else begin
                    state_s = RUN;
                end
            end
            FINISH: begin
                busy_s  = 1'b0;
                done_s  = 1'b1;
                state_s = IDLE;
                if (is_div_r) begin
`ifdef MDU_DIV_EN
                    if (dz_r) begin
                        lo_s       = {WIDTH{1'b1}};
                        hi_s       = rs_orig_r;
                        div_zero_s = 1'b1;
                    end else begin
                        lo_s = quo_s;
                        hi_s = rem_s;
                    end
`else
                    hi_s = hi_r;
                    lo_s = lo_r;
`endif
                end else begin
                    {hi_s, lo_s} = neg_res_r ? prod_neg_s : prod_raw_s;
                end
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            is_div_r  <= 1'b0;
            neg_res_r <= 1'b0;
            acc_r     <= {WIDTH{1'b0}};
            opq_r     <= {WIDTH{1'b0}};
            opd_r     <= {WIDTH{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
`ifdef MDU_DIV_EN
            neg_rem_r  <= 1'b0;
            dz_r       <= 1'b0;
            rs_orig_r  <= {WIDTH{1'b0}};
            div_zero_r <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            is_div_r  <= is_div_s;
            neg_res_r <= neg_res_s;
            acc_r     <= acc_s;
            opq_r     <= opq_s;
            opd_r     <= opd_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            hi_r      <= hi_s;
            lo_r      <= lo_s;
`ifdef MDU_DIV_EN
            neg_rem_r  <= neg_rem_s;
            dz_r       <= dz_s;
            rs_orig_r  <= rs_orig_s;
            div_zero_r <= div_zero_s;
`endif
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;
`ifdef MDU_DIV_EN
    assign div_zero = div_zero_r;
`else
    assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mdu_hilo_unit.sv
// Self-checking bench for mdu_hilo_unit: directed vector table plus start-while-busy
// and mid-operation reset sequences. Expectations follow MDU_DIV_EN the same way as the RTL.
module tb_mdu_hilo_unit;
    import mdu_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    logic e0_busy, mid_busy_ok, done_busy;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dz;
        logic        exp_busy;
        int          exp_lat;
    } vec_t;

    vec_t vecs[5];

    mdu_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Issues one op, scrambles operands after E0, optionally pulses start or
    // asserts reset at cycle k, and reports the edge index at which done rose.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int pulse_at, input int reset_at, output int lat);
        lat = -1;
        mid_busy_ok = 1'b1;
        done_busy = 1'b1;
        @(negedge clk);
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; rs_val = $urandom; rt_val = $urandom;
        e0_busy = busy;
        for (int k = 1; k <= 40; k++) begin
            if (k == reset_at) begin
                #1 reset = 1'b1;
                #1;
                chk("rst_mid_hi", {32'h0, hi}, 64'h0);
                chk("rst_mid_lo", {32'h0, lo}, 64'h0);
                chk("rst_mid_busy", {63'h0, busy}, 64'h0);
                chk("rst_mid_done", {63'h0, done}, 64'h0);
                #1 reset = 1'b0;
                return;
            end
            if (k == pulse_at) begin
                start = 1'b1; op = MDU_MULTU; rs_val = 32'd7; rt_val = 32'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                lat = k;
                done_busy = busy;
                break;
            end
            if (busy !== 1'b1) mid_busy_ok = 1'b0;
        end
    endtask

    initial begin
        int lat;
        logic [31:0] hold_hi, hold_lo;

        vecs[0] = '{MDU_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b1, 33};
        vecs[1] = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b1, 33};
`ifdef MDU_DIV_EN
        vecs[2] = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b1, 33};
        vecs[3] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b1, 33};
        vecs[4] = '{MDU_DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1, 1'b1, 33};
`else
        vecs[2] = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, 1};
        vecs[3] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, 1};
        vecs[4] = '{MDU_DIVU,  32'd100,      32'd0,        32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, 1};
`endif

        reset = 1'b1; start = 1'b0; op = 2'b00; rs_val = 32'h0; rt_val = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {63'h0, busy}, 64'h0);
        chk("reset_done", {63'h0, done}, 64'h0);
        chk("reset_dz", {63'h0, div_zero}, 64'h0);
        chk("reset_hilo", {hi, lo}, 64'h0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            do_op(vecs[i].op, vecs[i].rs, vecs[i].rt, 0, 0, lat);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            chk($sformatf("v%0d_busy_e0", i), {63'h0, e0_busy}, {63'h0, vecs[i].exp_busy});
            chk($sformatf("v%0d_busy_run", i), {63'h0, mid_busy_ok}, 64'h1);
            chk($sformatf("v%0d_busy_done", i), {63'h0, done_busy}, 64'h0);
            chk($sformatf("v%0d_hi", i), {32'h0, hi}, {32'h0, vecs[i].exp_hi});
            chk($sformatf("v%0d_lo", i), {32'h0, lo}, {32'h0, vecs[i].exp_lo});
            chk($sformatf("v%0d_dz", i), {63'h0, div_zero}, {63'h0, vecs[i].exp_dz});
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_done_clr", i), {63'h0, done}, 64'h0);
            chk($sformatf("v%0d_dz_clr", i), {63'h0, div_zero}, 64'h0);
            chk($sformatf("v%0d_hilo_hold", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
        end

        // Robustness: MULTU 5*6, then MULT 2*3 with a stray start at E10.
        do_op(MDU_MULTU, 32'd5, 32'd6, 0, 0, lat);
        chk("seq_multu_lat", 64'(lat), 64'd33);
        chk("seq_multu", {hi, lo}, 64'd30);
        do_op(MDU_MULT, 32'd2, 32'd3, 10, 0, lat);
        chk("seq_pulse_lat", 64'(lat), 64'd33);
        chk("seq_pulse_res", {hi, lo}, 64'd6);
        hold_hi = hi; hold_lo = lo;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("seq_pulse_idle_busy", {63'h0, busy}, 64'h0);
        chk("seq_pulse_idle_done", {63'h0, done}, 64'h0);
        chk("seq_pulse_hold", {hi, lo}, {hold_hi, hold_lo});

        // Reset mid-RUN, then a normal signed multiply.
        do_op(MDU_MULTU, 32'd9, 32'd9, 0, 6, lat);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("post_rst_idle_busy", {63'h0, busy}, 64'h0);
        do_op(MDU_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, lat);
        chk("post_rst_lat", 64'(lat), 64'd33);
        chk("post_rst_res", {hi, lo}, 64'h0000000000000001);
        do_op(MDU_MULT, 32'h80000000, 32'h80000000, 0, 0, lat);
        chk("min_sq_res", {hi, lo}, 64'h4000000000000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
